// File: rtl/bus_rr_controller.sv
// -----------------------------------------------------------------------------
// bus_rr_controller
//
// Central controller for a shared parallel bus. Arbitrates round-robin among
// driver FIFOs with data pending, pops one packet from the winner, decodes the
// destination byte in the packet's top bits and pushes the unmodified packet
// into the destination driver (or every other driver on a broadcast ID).
// One packet moves per four clock cycles: IDLE -> POP -> ROUTE -> PUSH.
//
// Handshake: pop[i] and push[i] are single-cycle strobes with no back-pressure.
// A driver asserting pndng[i] guarantees D_pop[i] holds its FIFO head until the
// cycle its pop strobe is seen; the packet is sampled at the edge that ends the
// pop cycle. A receiving driver must accept D_push[i] in the cycle push[i] is
// high.
//
// Ports:
//   clk       bus clock, rising edge
//   reset     asynchronous active-low reset
//   pndng     per-driver "FIFO not empty"
//   D_pop     per-driver FIFO head word (first-word-fall-through)
//   pop       per-driver pop strobe (at most one bit set)
//   push      per-driver push strobe (high only in PUSH)
//   D_push    per-driver delivered packet (zero outside PUSH)
//   grant_id  index of the driver currently or last granted
//   busy      high whenever the FSM is not IDLE
//   drop_cnt  saturating count of discarded packets
// -----------------------------------------------------------------------------
module bus_rr_controller #(
    parameter int          pckg_sz   = 16,
    parameter int          drvrs     = 4,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [drvrs-1:0]                pndng,
    input  logic [drvrs-1:0][pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]                pop,
    output logic [drvrs-1:0]                push,
    output logic [drvrs-1:0][pckg_sz-1:0]   D_push,
    output logic [7:0]                      grant_id,
    output logic                            busy,
    output logic [15:0]                     drop_cnt
);

    localparam int IDX_W = $clog2(drvrs);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POP   = 2'd1,
        ROUTE = 2'd2,
        PUSH  = 2'd3
    } state_t;

    state_t                          state_q,   state_d;
    logic [IDX_W-1:0]                rr_ptr_q,  rr_ptr_d;
    logic [IDX_W-1:0]                win_q,     win_d;
    logic [pckg_sz-1:0]              pkt_q,     pkt_d;
    logic [drvrs-1:0]                pop_q,     pop_d;
    logic [drvrs-1:0]                push_q,    push_d;
    logic [drvrs-1:0][pckg_sz-1:0]   d_push_q,  d_push_d;
    logic [15:0]                     drop_cnt_q, drop_cnt_d;

    // Round-robin search: candidates run rr_ptr+1, rr_ptr+2, ... with wrap.
    // The loop walks from the farthest offset to the nearest so the last hit
    // written is the closest pending driver after the last grant.
    logic [IDX_W:0]   cand;
    logic [IDX_W-1:0] sel;
    logic             sel_vld;

    always_comb begin
        cand    = '0;
        sel     = '0;
        sel_vld = 1'b0;
        for (int off = drvrs; off >= 1; off--) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(off);
            if (cand >= (IDX_W+1)'(drvrs)) begin
                cand = cand - (IDX_W+1)'(drvrs);
            end
            if (pndng[cand[IDX_W-1:0]]) begin
                sel     = cand[IDX_W-1:0];
                sel_vld = 1'b1;
            end
        end
    end

    logic [7:0] dest;
    assign dest = pkt_q[pckg_sz-1 -: 8];

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        win_d      = win_q;
        pkt_d      = pkt_q;
        pop_d      = '0;
        push_d     = '0;
        d_push_d   = '0;
        drop_cnt_d = drop_cnt_q;

        case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    pop_d[sel] = 1'b1;
                    win_d      = sel;
                    state_d    = POP;
                end
            end
            POP: begin
                // Pop strobe is visible this cycle; the head word is taken at
                // the edge that ends it. The winner becomes lowest priority.
                pkt_d    = D_pop[win_q];
                rr_ptr_d = win_q;
                state_d  = ROUTE;
            end
            ROUTE: begin
                // Broadcast is decoded first so it wins even if the ID
                // happened to fall inside the driver range.
                if (dest == broadcast) begin
                    for (int i = 0; i < drvrs; i++) begin
                        if (IDX_W'(i) != win_q) begin
                            push_d[i]   = 1'b1;
                            d_push_d[i] = pkt_q;
                        end
                    end
                end else if ((dest < 8'(drvrs)) && (dest != 8'(win_q))) begin
                    push_d[dest[IDX_W-1:0]]   = 1'b1;
                    d_push_d[dest[IDX_W-1:0]] = pkt_q;
                end else if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
                state_d = PUSH;
            end
            PUSH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= IDX_W'(drvrs - 1);
            win_q      <= '0;
            pkt_q      <= '0;
            pop_q      <= '0;
            push_q     <= '0;
            d_push_q   <= '0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            win_q      <= win_d;
            pkt_q      <= pkt_d;
            pop_q      <= pop_d;
            push_q     <= push_d;
            d_push_q   <= d_push_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign pop      = pop_q;
    assign push     = push_q;
    assign D_push   = d_push_q;
    assign grant_id = 8'(win_q);
    assign busy     = (state_q != IDLE);
    assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_bus_rr_controller.sv
// -----------------------------------------------------------------------------
// tb_bus_rr_controller
//
// Drives per-driver FIFO models into bus_rr_controller. A reference model
// computes, at load time, the grant order and the push pattern of each packet
// and queues them; a negedge monitor pops one entry per observed pop strobe and
// checks the pop/grant, then the push vector and data two cycles later.
// -----------------------------------------------------------------------------
module tb_bus_rr_controller;

    localparam int DRV = 4;
    localparam int PW  = 16;
    localparam int RW  = 8 + DRV + PW;   // {grant, push vector, packet}

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DRV-1:0]         pndng = '0;
    logic [DRV-1:0][PW-1:0] d_pop = '0;
    logic [DRV-1:0]         pop;
    logic [DRV-1:0]         push;
    logic [DRV-1:0][PW-1:0] d_push;
    logic [7:0]             grant_id;
    logic                   busy;
    logic [15:0]            drop_cnt;

    bus_rr_controller #(.pckg_sz(PW), .drvrs(DRV), .broadcast(8'hFF)) dut (
        .clk      (clk),
        .reset    (rst_n),
        .pndng    (pndng),
        .D_pop    (d_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (d_push),
        .grant_id (grant_id),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    // ---------------- scoreboard state ----------------
    logic [RW-1:0] exp_q[$];
    logic [RW-1:0] cur;
    int            pop_t[$];
    int            n_tests = 0;
    int            n_fail  = 0;
    int            cyc     = 0;
    bit            pend    = 1'b0;
    int            cnt     = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver FIFO models ----------------
    logic [PW-1:0]  mem[DRV][8];
    int             wr_p[DRV];
    int             rd_p[DRV];
    int             m_rd[DRV];
    logic [DRV-1:0] pop_prev = '0;
    int             m_rr   = DRV - 1;
    int             m_drop = 0;

    // The head leaves the FIFO at the edge that ends the pop cycle, so the
    // dequeue is applied one negedge after the strobe was seen.
    always @(negedge clk) begin
        for (int i = 0; i < DRV; i++) begin
            if (pop_prev[i]) rd_p[i]++;
        end
        pop_prev = pop;
        for (int i = 0; i < DRV; i++) begin
            pndng[i] = (rd_p[i] != wr_p[i]);
            d_pop[i] = pndng[i] ? mem[i][rd_p[i] % 8] : '0;
        end
    end

    task automatic send(input int src, input logic [PW-1:0] p);
        mem[src][wr_p[src] % 8] = p;
        wr_p[src]++;
    endtask

    // Reference: round-robin grant order over everything loaded so far.
    task automatic model_run();
        bit             any;
        int             w;
        logic [PW-1:0]  p;
        logic [7:0]     dest;
        logic [DRV-1:0] vec;
        do begin
            any = 1'b0;
            w   = 0;
            for (int off = DRV; off >= 1; off--) begin
                int c;
                c = (m_rr + off) % DRV;
                if (m_rd[c] != wr_p[c]) begin
                    any = 1'b1;
                    w   = c;
                end
            end
            if (any) begin
                p = mem[w][m_rd[w] % 8];
                m_rd[w]++;
                m_rr = w;
                dest = p[PW-1 -: 8];
                vec  = '0;
                if (dest == 8'hFF) begin
                    for (int j = 0; j < DRV; j++) vec[j] = (j != w);
                end else if (dest < 8'(DRV) && int'(dest) != w) begin
                    vec[dest[1:0]] = 1'b1;
                end else if (m_drop < 65535) begin
                    m_drop++;
                end
                exp_q.push_back({8'(w), vec, p});
            end
        end while (any);
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            pend = 1'b0;
        end else begin
            if (pend) begin
                cnt++;
                if (cnt == 1) begin
                    check("pop_one_cycle", pop, 0);
                end else if (cnt == 2) begin
                    check("push_vec", push, cur[PW +: DRV]);
                    for (int i = 0; i < DRV; i++) begin
                        check("d_push", d_push[i], cur[PW+i] ? cur[PW-1:0] : '0);
                    end
                end else begin
                    check("push_clear", push, 0);
                    check("busy_end", busy, 0);
                    pend = 1'b0;
                end
            end else if (push != '0) begin
                check("stray_push", push, 0);
            end
            if (pop != '0) begin
                pop_t.push_back(cyc);
                if (exp_q.size() == 0) begin
                    check("unexp_pop", pop, 0);
                end else begin
                    cur = exp_q.pop_front();
                    check("pop_vec", pop, DRV'(1) << cur[RW-1 -: 8]);
                    check("grant_id", grant_id, cur[RW-1 -: 8]);
                    check("busy", busy, 1);
                    pend = 1'b1;
                    cnt  = 0;
                end
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic wait_done();
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !pend && !busy && pndng == '0) return;
        end
        check("timeout_exp_left", exp_q.size(), 0);
    endtask

    task automatic sync_model();
        exp_q.delete();
        m_rr   = DRV - 1;
        m_drop = 0;
        for (int i = 0; i < DRV; i++) m_rd[i] = rd_p[i];
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        sync_model();
        rst_n = 1'b1;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit seen;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_pop", pop, 0);
        check("rst_push", push, 0);
        check("rst_d_push", d_push, 0);
        check("rst_grant", grant_id, 0);
        check("rst_busy", busy, 0);
        check("rst_drop", drop_cnt, 0);
        sync_model();
        rst_n = 1'b1;

        // Unicast: driver 1 -> driver 2
        @(negedge clk);
        send(1, 16'h02AB);
        model_run();
        wait_done();
        check("uni_drop", drop_cnt, 0);

        // Fairness: all drivers pending, two packets each
        apply_reset();
        pop_t.delete();
        for (int i = 0; i < DRV; i++) begin
            for (int r = 0; r < 2; r++) begin
                send(i, {8'((i + 1) % DRV), 8'(16 * i + r + $urandom_range(0, 7))});
            end
        end
        model_run();
        wait_done();
        check("fair_pops", pop_t.size(), 8);
        for (int k = 1; k < pop_t.size(); k++) begin
            check("pop_gap", pop_t[k] - pop_t[k-1], 4);
        end

        // Broadcast from driver 3
        @(negedge clk);
        send(3, 16'hFF5A);
        model_run();
        wait_done();
        check("bc_drop", drop_cnt, m_drop);

        // Drops: out-of-range destination, then self-addressed
        apply_reset();
        send(0, 16'h0711);
        send(0, 16'h0022);
        model_run();
        wait_done();
        check("drop_cnt2", drop_cnt, 2);

        // Reset while the packet sits in ROUTE
        @(negedge clk);
        send(2, 16'h0140);
        model_run();
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = (pop != '0);
        end
        check("mid_pop_seen", seen, 1);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("mid_pop", pop, 0);
        check("mid_push", push, 0);
        check("mid_busy", busy, 0);
        check("mid_drop", drop_cnt, 0);
        repeat (2) @(negedge clk);
        #1;
        sync_model();
        send(3, 16'h0000);
        send(1, 16'h0200);
        model_run();
        check("mid_first_grant", exp_q[0][RW-1 -: 8], 1);
        @(negedge clk);
        #1 rst_n = 1'b1;
        wait_done();

        // Saturation of the drop counter
        @(negedge clk);
        force dut.drop_cnt_q = 16'hFFFE;
        @(negedge clk);
        release dut.drop_cnt_q;
        #1;
        check("sat_preset", drop_cnt, 16'hFFFE);
        m_drop = 65534;
        for (int k = 0; k < 3; k++) send(0, 16'h0900 | 16'($urandom_range(0, 255)));
        model_run();
        wait_done();
        check("sat_drop", drop_cnt, 16'hFFFF);
        check("sat_model", drop_cnt, m_drop);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/bus_rr_controller.md
Name: bus_rr_controller

Overview:
- Central controller for the shared parallel bus: arbitrates among `drvrs` driver FIFOs that have data pending.
- Pops one packet from the winning driver, decodes its destination field and pushes the packet into the destination driver's input.
- One bus lane (bits=1); the per-driver pndng/pop/push/D_pop/D_push signals map one-to-one onto this block's ports.

Parameters:
- pckg_sz, 16, packet width in bits; must be ≥ 9.
- drvrs, 4, number of drivers on the bus; 2..255.
- broadcast, 8'hFF, destination ID meaning "all drivers except source".

Ports:
- clk  input  1  bus clock; all logic on rising edge
- reset  input  1  asynchronous, active-low; 0 clears all state immediately
- pndng  input  [drvrs-1:0]  driver i FIFO non-empty; head word valid on D_pop[i]
- D_pop  input  [pckg_sz-1:0] x drvrs  head word of driver i FIFO (first-word-fall-through)
- pop  output  [drvrs-1:0]  one-cycle pop strobe to driver i
- push  output  [drvrs-1:0]  one-cycle push strobe to driver i
- D_push  output  [pckg_sz-1:0] x drvrs  packet delivered to driver i
- grant_id  output  8  index of driver currently or last granted
- busy  output  1  high whenever FSM is not IDLE
- drop_cnt  output  16  count of discarded packets; saturates at 16'hFFFF

Behaviour:
- Packet format: dest = pkt[pckg_sz-1 -: 8]; payload = remaining bits. The packet is forwarded unmodified.
- Outputs are registered.
- Reset (reset=0) values: pop=0, push=0, D_push=all 0, grant_id=0, busy=0, drop_cnt=0, FSM=IDLE, rr_ptr=drvrs-1.
- Reset mid-operation discards any in-flight packet. No pop or push strobe survives reset.
- FSM states and transitions:
  - IDLE:
    - Stays here if pndng==0.
    - Otherwise selects winner w = first i with pndng[i]=1, searching (rr_ptr+1) mod drvrs upward with wrap.
    - Registers pop[w]=1 and grant_id=w, then goes to POP.
  - POP:
    - pop[w] is high for exactly this cycle.
    - At the next edge: captures pkt<=D_pop[w], clears pop, sets rr_ptr<=w, goes to ROUTE.
  - ROUTE: at the next edge, registers one of:
    - dest<drvrs and dest!=w: push[dest]=1, D_push[dest]=pkt.
    - dest==broadcast: push[i]=1 and D_push[i]=pkt for every i!=w.
    - otherwise (out of range, or dest==w): no push; drop_cnt+1 (saturating).
    - Then goes to PUSH.
  - PUSH:
    - push strobes are high for exactly this cycle.
    - At the next edge: push cleared, D_push returns to 0, goes to IDLE.
- Timing:
  - pndng sampled at edge k → pop high in cycle k..k+1.
  - push high in cycle k+2..k+3.
  - Next pop no earlier than edge k+4, so throughput is 1 packet per 4 cycles.
- pndng changes while busy are ignored until IDLE. pndng[w] is not re-checked in POP; the driver guarantees the FIFO head stays valid until popped.
- At most one pop bit is high at any time. push bits are high only in PUSH.
- Round robin: a driver granted last has lowest priority next time. With all pndng high, grants run 0,1,2,...,drvrs-1,0.
- grant_id holds its value after PUSH until the next grant.
- busy = (state != IDLE).

Test Plan:
- Unicast:
  - Stimulus: reset released; driver 1 pending with D_pop[1]=16'h02AB (drvrs=4).
  - Required: pop=4'b0010 for 1 cycle; push=4'b0100 and D_push[2]=16'h02AB exactly 2 cycles later; drop_cnt=0.
- Fairness:
  - Stimulus: all 4 drivers continuously pending, valid destinations.
  - Required: grant order 0,1,2,3,0,1; pop strobes spaced 4 cycles apart.
- Broadcast:
  - Stimulus: driver 3 sends 16'hFF5A.
  - Required: push=4'b0111 for one cycle; D_push[0..2]=16'hFF5A; D_push[3]=0.
- Drops:
  - Stimulus: driver 0 sends 16'h0711 (dest 7 out of range), then 16'h0022 (self-addressed).
  - Required: both popped, no push; drop_cnt=2.
- Reset mid-flight:
  - Stimulus: reset asserted during ROUTE.
  - Required: immediately pop=0, push=0, busy=0, drop_cnt=0; no push after release; first grant after release goes to lowest pending index.
- Saturation:
  - Stimulus: force drop_cnt to 16'hFFFE; send 3 invalid packets.
  - Required: drop_cnt ends at 16'hFFFF.
